// File: rtl/mem_read_responder_if.sv
// Request/response bundle for mem_read_responder: one request per cycle in,
// fixed-latency read responses and an in-flight count out.
interface mem_read_responder_if;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  pending;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, pending
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, pending
    );
endinterface

// File: rtl/mem_read_responder.sv
// Word-addressed 16-bit memory with writes committed immediately and reads
// returned through a fixed LATENCY-stage pipeline, fully pipelined and in order.
module mem_read_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_read_responder_if.slave  bus
);

    localparam int WORDS = 1 << ADDR_BITS;

    logic [15:0]          mem_r [WORDS];
    logic [ADDR_BITS-1:0] idx_s;
    logic                 rd_s;
    logic                 wr_s;
    logic [15:0]          rd_word_s;
    logic [LATENCY-1:0]   valid_r;
    logic [15:0]          data_r [LATENCY];
    logic [3:0]           pending_r;
    logic [3:0]           pending_nxt_s;
    logic                 unused_s;

    // Byte address to word index; bit 0 and bits above the index alias away.
    assign idx_s     = bus.addr[ADDR_BITS:1];
    assign unused_s  = ^{bus.addr[15:ADDR_BITS+1], bus.addr[0]};
    assign rd_word_s = mem_r[idx_s];

    // Request decode; nothing is accepted while reset is held.
    always_comb begin
        rd_s = 1'b0;
        wr_s = 1'b0;
        if (bus.enable && rst_n) begin
            rd_s = !bus.wr;
            wr_s = bus.wr;
        end else begin
            rd_s = 1'b0;
            wr_s = 1'b0;
        end
    end

    // Storage array: not reset, so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[idx_s] <= bus.data_in;
        end
    end

    // Response shift pipeline; data only moves with a valid token, so the
    // last stage holds the previously delivered word while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                data_r[i] <= 16'h0000;
            end
        end else begin
            valid_r[0] <= rd_s;
            if (rd_s) begin
                data_r[0] <= rd_word_s;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                if (valid_r[i-1]) begin
                    data_r[i] <= data_r[i-1];
                end
            end
        end
    end

    // In-flight count: +1 on issue, -1 on the cycle a response is presented.
    always_comb begin
        pending_nxt_s = pending_r;
        case ({rd_s, valid_r[LATENCY-1]})
            2'b10:   pending_nxt_s = pending_r + 4'd1;
            2'b01:   pending_nxt_s = pending_r - 4'd1;
            default: pending_nxt_s = pending_r;
        endcase
    end

    // In-flight counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 4'd0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    assign bus.data_valid = valid_r[LATENCY-1];
    assign bus.data_out   = data_r[LATENCY-1];
    assign bus.pending    = pending_r;

endmodule

// File: tb/tb_mem_read_responder.sv
// Scoreboard bench for mem_read_responder: reads push expected data and due
// cycle; a negedge monitor pops and checks data, timing, hold and pending.
module tb_mem_read_responder;

    localparam int LAT = 4;

    typedef struct {
        logic [15:0] data;
        int          issue;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   valid_cnt;
    int   max_pend;
    logic [15:0] last_data;
    logic [15:0] mdl [1024];
    exp_t q[$];

    mem_read_responder_if bus ();

    mem_read_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare outputs against the scoreboard once per cycle.
    always @(negedge clk) begin
        int  n;
        bit  exp_v;
        if (rst_n === 1'b1) begin
            n = 0;
            foreach (q[i]) if (q[i].issue <= cyc) n++;
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            checks++;
            if (bus.pending !== 4'(n)) begin
                errors++;
                $display("FAIL pending cyc=%0d got %0d expected %0d", cyc, bus.pending, n);
            end
            checks++;
            if (bus.data_valid !== exp_v) begin
                errors++;
                $display("FAIL data_valid cyc=%0d got %b expected %b", cyc, bus.data_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (bus.data_out !== q[0].data) begin
                    errors++;
                    $display("FAIL data_out cyc=%0d got %h expected %h", cyc, bus.data_out, q[0].data);
                end
                last_data = q[0].data;
                valid_cnt++;
                void'(q.pop_front());
            end else if (bus.data_valid !== 1'b1) begin
                checks++;
                if (bus.data_out !== last_data) begin
                    errors++;
                    $display("FAIL data_out_hold cyc=%0d got %h expected %h", cyc, bus.data_out, last_data);
                end
            end
            if (int'(bus.pending) > max_pend) max_pend = int'(bus.pending);
        end
    end

    task automatic step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        @(posedge clk);
        #2;
        bus.enable  = en;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        if (en && !w) begin
            e.data  = mdl[a[10:1]];
            e.issue = cyc + 1;
            e.due   = cyc + LAT;
            q.push_back(e);
        end else if (en && w) begin
            mdl[a[10:1]] = d;
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        while (q.size() > 0 && i < 20) begin
            step(1'b0, 1'b0, 16'h0000, 16'h0000);
            i++;
        end
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout outstanding %0d expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.wr = 1'b0; bus.addr = 16'h0000; bus.data_in = 16'h0000;
        #3;
        checks++;
        if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.data_valid); end
        checks++;
        if (bus.pending !== 4'd0) begin errors++; $display("FAIL reset_pending got %0d expected 0", bus.pending); end
        checks++;
        if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL reset_data got %h expected 0000", bus.data_out); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_single();
        int v0;
        step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        v0 = valid_cnt;
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        drain();
        checks++;
        if (valid_cnt - v0 != 1) begin errors++; $display("FAIL single_count got %0d expected 1", valid_cnt - v0); end
        checks++;
        if (bus.data_out !== 16'hBEEF) begin errors++; $display("FAIL single_hold got %h expected beef", bus.data_out); end
    endtask

    task automatic test_burst();
        int v0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(16'h0100 + 2*i), 16'(16'h1000 + i));
        max_pend = 0;
        v0 = valid_cnt;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(16'h0100 + 2*i), 16'h0000);
        drain();
        checks++;
        if (max_pend != LAT) begin errors++; $display("FAIL burst_peak got %0d expected %0d", max_pend, LAT); end
        checks++;
        if (valid_cnt - v0 != 8) begin errors++; $display("FAIL burst_count got %0d expected 8", valid_cnt - v0); end
        checks++;
        if (bus.data_out !== 16'h1007) begin errors++; $display("FAIL burst_last got %h expected 1007", bus.data_out); end
    endtask

    task automatic test_write_after_read();
        step(1'b1, 1'b1, 16'h0020, 16'h1111);
        step(1'b1, 1'b0, 16'h0020, 16'h0000);
        step(1'b1, 1'b1, 16'h0020, 16'h2222);
        step(1'b1, 1'b0, 16'h0020, 16'h0000);
        drain();
        checks++;
        if (bus.data_out !== 16'h2222) begin errors++; $display("FAIL war_last got %h expected 2222", bus.data_out); end
    endtask

    task automatic test_alias();
        step(1'b1, 1'b1, 16'h0802, 16'hA5A5);
        step(1'b1, 1'b0, 16'h0002, 16'h0000);
        step(1'b1, 1'b0, 16'h0003, 16'h0000);
        drain();
        checks++;
        if (bus.data_out !== 16'hA5A5) begin errors++; $display("FAIL alias_last got %h expected a5a5", bus.data_out); end
    endtask

    task automatic test_idle_gap();
        int v0;
        v0 = valid_cnt;
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 1'b0, 16'h0102, 16'h0000);
        drain();
        checks++;
        if (valid_cnt - v0 != 2) begin errors++; $display("FAIL idle_count got %0d expected 2", valid_cnt - v0); end
    endtask

    task automatic test_reset_mid();
        int v0;
        step(1'b1, 1'b1, 16'h0030, 16'h7777);
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(16'h0100 + 2*i), 16'h0000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        last_data = 16'h0000;
        bus.enable = 1'b1; bus.wr = 1'b1; bus.addr = 16'h0030; bus.data_in = 16'hDEAD;
        #1;
        checks++;
        if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", bus.data_valid); end
        checks++;
        if (bus.pending !== 4'd0) begin errors++; $display("FAIL midrst_pending got %0d expected 0", bus.pending); end
        checks++;
        if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL midrst_data got %h expected 0000", bus.data_out); end
        repeat (2) @(posedge clk);
        #2;
        bus.enable = 1'b0;
        rst_n = 1'b1;
        v0 = valid_cnt;
        step(1'b1, 1'b0, 16'h0030, 16'h0000);
        step(1'b1, 1'b0, 16'h0100, 16'h0000);
        drain();
        checks++;
        if (valid_cnt - v0 != 2) begin errors++; $display("FAIL midrst_count got %0d expected 2", valid_cnt - v0); end
        checks++;
        if (bus.data_out !== 16'h1000) begin errors++; $display("FAIL midrst_preserved got %h expected 1000", bus.data_out); end
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0; valid_cnt = 0; max_pend = 0;
        last_data = 16'h0000;
        test_reset();
        test_single();
        test_burst();
        test_write_after_read();
        test_alias();
        test_idle_gap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_read_responder.md
MEM_READ_RESPONDER -- requirements
Module: mem_read_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning log2 of the word count (1024 x 16-bit words).
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from request to data_valid (legal range 1..8).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1, meaning a request is presented this cycle.
REQ-006 SHALL have port wr, input, 1, meaning a write when 1 and a read when 0; ignored when enable=0.
REQ-007 SHALL have port addr, input, 16, meaning the byte address.
REQ-008 SHALL have port data_in, input, 16, meaning the write data.
REQ-009 SHALL have port data_out, output, 16, meaning the read data; meaningful only while data_valid=1.
REQ-010 SHALL have port data_valid, output, 1, meaning data_out holds the response to a read.
REQ-011 SHALL have port pending, output, 4, meaning the number of reads issued whose response has not yet been delivered.

Function
REQ-012 SHALL compute the word index as addr[ADDR_BITS:1].
- addr[0] ignored.
- addr bits above ADDR_BITS ignored; upper addresses alias and wrap.
REQ-013 SHALL commit a write (enable=1, wr=1) to the array at the same clock edge.
- A write produces no response.
- A write does not change pending.
REQ-014 SHALL sample array contents for a read (enable=1, wr=0) at its issue edge.
- A write in the same cycle is impossible: there is one request per cycle.
- A write in any later cycle does not alter an in-flight read's data.
REQ-015 SHALL deliver each read's data with data_valid=1 for exactly one cycle.
- Delivery occurs LATENCY cycles after the issue edge: request sampled at edge N, data_valid high during the cycle after edge N+LATENCY-1.
REQ-016 SHALL be fully pipelined.
- A new read is accepted every cycle.
- Responses return in issue order.
- No request is ever stalled or dropped.
REQ-017 SHALL implement the delay as a LATENCY-stage shift pipeline; each stage holds a valid bit and 16 data bits.
REQ-018 SHALL update pending each edge as pending + (read issued) - (response delivered).
- Simultaneous issue and delivery leaves pending unchanged.
- Maximum value is LATENCY; pending never wraps.
REQ-019 SHALL hold data_out at its last delivered value while data_valid=0.
REQ-020 SHALL treat a write to a word with a read in flight as legal; the in-flight read returns the old value.
REQ-021 SHALL accept back-to-back reads to the same word; all responses carry identical data.
REQ-022 SHALL contain no control FSM beyond the pipeline valid bits and the pending counter.

Reset
REQ-023 SHALL, while rst_n=0, force all pipeline valid bits to 0, data_valid=0, data_out=16'h0000 and pending=0, independent of clk.
REQ-024 SHALL discard all in-flight reads when reset asserts mid-operation; none is delivered after rst_n deasserts.
REQ-025 SHALL NOT reset array contents.
REQ-026 SHALL ignore requests presented while rst_n=0.
REQ-027 SHALL accept a request on the first rising edge after rst_n deasserts.

Verification
REQ-028 Bench SHALL cover single read latency: write 16'hBEEF to addr 16'h0010; read addr 16'h0010 at edge N -> data_valid=1, data_out=16'hBEEF after edge N+3 only; pending 1,1,1,1 then 0.
REQ-029 Bench SHALL cover a burst: 8 consecutive reads, addr 16'h0100..16'h010E step 2, preloaded 16'h1000+i -> 8 consecutive valid cycles, data 16'h1000..16'h1007 in order; pending peaks at 4.
REQ-030 Bench SHALL cover write-after-read ordering: read addr 16'h0020 (holds 16'h1111), then write 16'h2222 there next cycle -> response 16'h1111; a following read returns 16'h2222.
REQ-031 Bench SHALL cover aliasing: write 16'hA5A5 to addr 16'h0802, read addr 16'h0002 and 16'h0003 -> both return 16'hA5A5.
REQ-032 Bench SHALL cover reset mid-burst: issue 3 reads, assert rst_n=0 between edges -> data_valid, pending, data_out go to 0 immediately; no data_valid after release; array data preserved.
REQ-033 Bench SHALL cover an idle gap: reads at edges N and N+2 -> data_valid high during the cycles after edges N+3 and N+5, low between.
